// File: rtl/spi_fifo_port_pkg.sv
// spi_fifo_port_pkg - register offsets, STATUS/CONTROL bit positions and bus FSM states. rev 1.0
`default_nettype none

package spi_fifo_port_pkg;

  localparam logic [1:0] FIFO_OFS_DATA    = 2'd0;
  localparam logic [1:0] FIFO_OFS_STATUS  = 2'd1;
  localparam logic [1:0] FIFO_OFS_CONTROL = 2'd2;
  localparam logic [1:0] FIFO_OFS_THRESH  = 2'd3;

  localparam int ST_RX_UNDERFLOW = 31;
  localparam int ST_TX_OVERFLOW  = 30;
  localparam int ST_RX_FULL      = 29;
  localparam int ST_TX_FULL      = 28;
  localparam int ST_RX_EMPTY     = 27;
  localparam int ST_TX_EMPTY     = 26;
  localparam int ST_TX_COUNT_LSB = 16;
  localparam int ST_RX_COUNT_LSB = 0;

  localparam int CTRL_RX_FLUSH = 0;
  localparam int CTRL_TX_FLUSH = 1;
  localparam int CTRL_CLR_RXUF = 2;
  localparam int CTRL_CLR_TXOF = 3;

  localparam int TH_IRQ_EN = 8;

  typedef enum logic [1:0] {
    BUS_IDLE  = 2'd0,
    BUS_READ  = 2'd1,
    BUS_WRITE = 2'd2,
    BUS_WAIT  = 2'd3
  } bus_state_e;

  function automatic logic [31:0] pack_status(
    input logic       rx_uf,
    input logic       tx_of,
    input logic       rx_full,
    input logic       tx_full,
    input logic       rx_empty,
    input logic       tx_empty,
    input logic [7:0] tx_cnt,
    input logic [7:0] rx_cnt
  );
    logic [31:0] s;
    s = '0;
    s[ST_RX_UNDERFLOW] = rx_uf;
    s[ST_TX_OVERFLOW]  = tx_of;
    s[ST_RX_FULL]      = rx_full;
    s[ST_TX_FULL]      = tx_full;
    s[ST_RX_EMPTY]     = rx_empty;
    s[ST_TX_EMPTY]     = tx_empty;
    s[ST_TX_COUNT_LSB +: 8] = tx_cnt;
    s[ST_RX_COUNT_LSB +: 8] = rx_cnt;
    return s;
  endfunction

endpackage

`default_nettype wire

// File: rtl/spi_fifo_port_sync_fifo.sv
// spi_fifo_port_sync_fifo - show-ahead synchronous FIFO with occupancy count and flush. rev 1.0
`default_nettype none

module spi_fifo_port_sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_flush,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_data,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_data,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_full,
  output logic                   o_empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  // A push into a full FIFO is refused even if a pop happens on the same edge.
  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;
  assign o_count   = r_count;
  assign o_data    = o_empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/spi_fifo_port.sv
// spi_fifo_port - SPI bus-cycle register window fronting a TX and an RX FIFO. rev 1.0
// Optional FIFO_IRQ_EN adds the THRESH register at 0xC and the irq output.
`default_nettype none

module spi_fifo_port
  import spi_fifo_port_pkg::*;
#(
  parameter logic [12:0] BASE_ADDR = 13'h0200,
  parameter int          DEPTH     = 16,
  parameter int          WIDTH     = 32
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             cs,
  input  logic             wr0,
  input  logic             wr1,
  input  logic             wr2,
  input  logic             wr3,
  input  logic [12:0]      addr,
  input  logic [WIDTH-1:0] dataIn,
  output logic [WIDTH-1:0] dataOut,
  input  logic [WIDTH-1:0] rxData,
  input  logic             rxValid,
  output logic             rxReady,
  output logic [WIDTH-1:0] txData,
  output logic             txValid,
  input  logic             txReady
`ifdef FIFO_IRQ_EN
  ,
  output logic             irq
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;

  bus_state_e       r_state;
  logic [1:0]       r_ofs;
  logic             r_rx_empty_cap;
  logic             r_rx_uf;
  logic             r_tx_of;
  logic             r_ready_en;

  logic [WIDTH-1:0] w_rx_head;
  logic [CW-1:0]    w_rx_count;
  logic             w_rx_full;
  logic             w_rx_empty;
  logic [WIDTH-1:0] w_tx_head;
  logic [CW-1:0]    w_tx_count;
  logic             w_tx_full;
  logic             w_tx_empty;

  logic             w_hit;
  logic [1:0]       w_ofs;
  logic             w_any_wr;
  logic             w_rise;
  logic             w_rd_start;
  logic             w_wr_start;
  logic             w_tx_push;
  logic             w_ctrl_wr;
  logic             w_rx_flush;
  logic             w_tx_flush;
  logic             w_rx_pop;
  logic             w_rx_push;
  logic             w_tx_pop;
  logic             w_uf_set;
  logic             w_uf_clr;
  logic             w_of_set;
  logic             w_of_clr;
  logic [WIDTH-1:0] w_status;
  logic [WIDTH-1:0] w_rd_data;
  logic             w_unused_ok;

  assign w_hit    = (addr[12:4] == BASE_ADDR[12:4]);
  assign w_ofs    = addr[3:2];
  assign w_any_wr = wr0 | wr1 | wr2 | wr3;

  // The FSM only leaves IDLE on cs and only returns on !cs, so IDLE with cs high is the rising edge.
  assign w_rise     = (r_state == BUS_IDLE) & cs;
  assign w_rd_start = w_rise & w_hit & ~w_any_wr;
  assign w_wr_start = w_rise & w_hit & w_any_wr;

  assign w_tx_push  = w_wr_start & (w_ofs == FIFO_OFS_DATA) & wr0 & wr1 & wr2 & wr3;
  assign w_ctrl_wr  = w_wr_start & (w_ofs == FIFO_OFS_CONTROL) & wr0;
  assign w_rx_flush = w_ctrl_wr & dataIn[CTRL_RX_FLUSH];
  assign w_tx_flush = w_ctrl_wr & dataIn[CTRL_TX_FLUSH];

  assign w_rx_pop  = (r_state == BUS_READ) & ~cs & (r_ofs == FIFO_OFS_DATA) & ~r_rx_empty_cap;
  assign rxReady   = r_ready_en & ~w_rx_full;
  assign w_rx_push = rxValid & rxReady;
  assign txValid   = ~w_tx_empty;
  assign txData    = w_tx_head;
  assign w_tx_pop  = txValid & txReady;

  assign w_uf_set = w_rd_start & (w_ofs == FIFO_OFS_DATA) & w_rx_empty;
  assign w_uf_clr = w_ctrl_wr & dataIn[CTRL_CLR_RXUF];
  assign w_of_set = w_tx_push & w_tx_full;
  assign w_of_clr = w_ctrl_wr & dataIn[CTRL_CLR_TXOF];

  assign w_status = pack_status(r_rx_uf, r_tx_of, w_rx_full, w_tx_full, w_rx_empty, w_tx_empty,
                                8'(w_tx_count), 8'(w_rx_count));

  assign w_unused_ok = &{1'b0, addr[1:0], dataIn[WIDTH-1:4]};

`ifdef FIFO_IRQ_EN
  logic [7:0] r_rx_level;
  logic       r_irq_en;
  logic       r_irq;
  logic       w_th_wr;

  assign w_th_wr = w_wr_start & (w_ofs == FIFO_OFS_THRESH);
  assign irq     = r_irq;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_rx_level <= '0;
      r_irq_en   <= 1'b0;
      r_irq      <= 1'b0;
    end else begin
      if (w_th_wr & wr0) r_rx_level <= dataIn[7:0];
      if (w_th_wr & wr1) r_irq_en   <= dataIn[TH_IRQ_EN];
      r_irq <= r_irq_en & (((8'(w_rx_count) >= r_rx_level) && (r_rx_level != 8'd0))
                           | r_rx_uf | r_tx_of);
    end
  end
`endif

  always_comb begin
    w_rd_data = '0;
    case (w_ofs)
      FIFO_OFS_DATA:   w_rd_data = w_rx_head;
      FIFO_OFS_STATUS: w_rd_data = w_status;
`ifdef FIFO_IRQ_EN
      FIFO_OFS_THRESH: w_rd_data = {{(WIDTH-9){1'b0}}, r_irq_en, r_rx_level};
`endif
      default:         w_rd_data = '0;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state        <= BUS_IDLE;
      r_ofs          <= FIFO_OFS_DATA;
      r_rx_empty_cap <= 1'b1;
      r_rx_uf        <= 1'b0;
      r_tx_of        <= 1'b0;
      r_ready_en     <= 1'b0;
      dataOut        <= '0;
    end else begin
      r_ready_en <= 1'b1;
      if (w_rd_start) begin
        dataOut <= w_rd_data;
      end else if (!cs) begin
        dataOut <= '0;
      end

      case (r_state)
        BUS_IDLE: begin
          if (cs) begin
            r_ofs          <= w_ofs;
            r_rx_empty_cap <= w_rx_empty;
            if (!w_hit)        r_state <= BUS_WAIT;
            else if (w_any_wr) r_state <= BUS_WRITE;
            else               r_state <= BUS_READ;
          end
        end
        default: begin
          if (!cs) r_state <= BUS_IDLE;
        end
      endcase

      if (w_uf_set)      r_rx_uf <= 1'b1;
      else if (w_uf_clr) r_rx_uf <= 1'b0;
      if (w_of_set)      r_tx_of <= 1'b1;
      else if (w_of_clr) r_tx_of <= 1'b0;
    end
  end

  spi_fifo_port_sync_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_rx_fifo (
    .clk     (clk),
    .rst_n   (resetN),
    .i_flush (w_rx_flush),
    .i_push  (w_rx_push),
    .i_data  (rxData),
    .i_pop   (w_rx_pop),
    .o_data  (w_rx_head),
    .o_count (w_rx_count),
    .o_full  (w_rx_full),
    .o_empty (w_rx_empty)
  );

  spi_fifo_port_sync_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_tx_fifo (
    .clk     (clk),
    .rst_n   (resetN),
    .i_flush (w_tx_flush),
    .i_push  (w_tx_push),
    .i_data  (dataIn),
    .i_pop   (w_tx_pop),
    .o_data  (w_tx_head),
    .o_count (w_tx_count),
    .o_full  (w_tx_full),
    .o_empty (w_tx_empty)
  );

endmodule

`default_nettype wire

// File: tb/tb_spi_fifo_port.sv
// tb_spi_fifo_port - directed self-checking bench for spi_fifo_port (default build).
`default_nettype none

module tb_spi_fifo_port;

  logic        clk = 1'b0;
  logic        resetN;
  logic        cs;
  logic        wr0, wr1, wr2, wr3;
  logic [12:0] addr;
  logic [31:0] dataIn;
  logic [31:0] dataOut;
  logic [31:0] rxData;
  logic        rxValid;
  logic        rxReady;
  logic [31:0] txData;
  logic        txValid;
  logic        txReady;

  int n_vec  = 0;
  int n_miss = 0;

  localparam logic [12:0] A_DATA = 13'h0200;
  localparam logic [12:0] A_STAT = 13'h0204;
  localparam logic [12:0] A_CTRL = 13'h0208;
  localparam logic [12:0] A_RSV  = 13'h020C;
  localparam logic [12:0] A_MISS = 13'h0300;

  always #5 clk = ~clk;

  spi_fifo_port #(.BASE_ADDR(13'h0200), .DEPTH(16), .WIDTH(32)) dut (
    .clk     (clk),
    .resetN  (resetN),
    .cs      (cs),
    .wr0     (wr0),
    .wr1     (wr1),
    .wr2     (wr2),
    .wr3     (wr3),
    .addr    (addr),
    .dataIn  (dataIn),
    .dataOut (dataOut),
    .rxData  (rxData),
    .rxValid (rxValid),
    .rxReady (rxReady),
    .txData  (txData),
    .txValid (txValid),
    .txReady (txReady)
  );

  task automatic bus_read(input logic [12:0] a, output logic [31:0] d);
    @(negedge clk);
    cs = 1'b1; addr = a; {wr3, wr2, wr1, wr0} = 4'b0000;
    @(negedge clk);
    d = dataOut; cs = 1'b0;
    @(negedge clk);
  endtask

  task automatic bus_write(input logic [12:0] a, input logic [31:0] v, input logic [3:0] lanes);
    @(negedge clk);
    cs = 1'b1; addr = a; dataIn = v; {wr3, wr2, wr1, wr0} = lanes;
    @(negedge clk);
    cs = 1'b0; {wr3, wr2, wr1, wr0} = 4'b0000;
    @(negedge clk);
  endtask

  task automatic fabric_push(input logic [31:0] v);
    @(negedge clk);
    rxValid = 1'b1; rxData = v;
    @(negedge clk);
    rxValid = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    resetN = 1'b0; cs = 1'b0; {wr3, wr2, wr1, wr0} = 4'b0000; addr = '0; dataIn = '0;
    rxData = '0; rxValid = 1'b0; txReady = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++; if (dataOut !== 32'h0) begin n_miss++; $display("FAIL reset_dataOut got %h exp %h", dataOut, 32'h0); end
    n_vec++; if (rxReady !== 1'b0) begin n_miss++; $display("FAIL reset_rxReady got %b exp 0", rxReady); end
    n_vec++; if (txValid !== 1'b0) begin n_miss++; $display("FAIL reset_txValid got %b exp 0", txValid); end
    n_vec++; if (txData !== 32'h0) begin n_miss++; $display("FAIL reset_txData got %h exp 0", txData); end
    resetN = 1'b1;
    @(negedge clk);
    n_vec++; if (rxReady !== 1'b1) begin n_miss++; $display("FAIL post_reset_rxReady got %b exp 1", rxReady); end
    bus_read(A_STAT, d);
    n_vec++; if (d !== 32'h0C000000) begin n_miss++; $display("FAIL reset_status got %h exp %h", d, 32'h0C000000); end
  endtask

  task automatic test_rx_order();
    logic [31:0] d;
    fabric_push(32'h11111111);
    fabric_push(32'h22222222);
    fabric_push(32'h33333333);
    bus_read(A_STAT, d);
    n_vec++; if (d !== 32'h04000003) begin n_miss++; $display("FAIL rx_status3 got %h exp %h", d, 32'h04000003); end
    bus_read(A_DATA, d);
    n_vec++; if (d !== 32'h11111111) begin n_miss++; $display("FAIL rx_word0 got %h exp %h", d, 32'h11111111); end
    bus_read(A_STAT, d);
    n_vec++; if (d !== 32'h04000002) begin n_miss++; $display("FAIL rx_status2 got %h exp %h", d, 32'h04000002); end
    bus_read(A_DATA, d);
    n_vec++; if (d !== 32'h22222222) begin n_miss++; $display("FAIL rx_word1 got %h exp %h", d, 32'h22222222); end
    bus_read(A_DATA, d);
    n_vec++; if (d !== 32'h33333333) begin n_miss++; $display("FAIL rx_word2 got %h exp %h", d, 32'h33333333); end
    bus_read(A_STAT, d);
    n_vec++; if (d !== 32'h0C000000) begin n_miss++; $display("FAIL rx_status0 got %h exp %h", d, 32'h0C000000); end
  endtask

  task automatic test_underflow();
    logic [31:0] d;
    bus_read(A_DATA, d);
    n_vec++; if (d !== 32'h0) begin n_miss++; $display("FAIL uf_data got %h exp 0", d); end
    bus_read(A_STAT, d);
    n_vec++; if (d !== 32'h8C000000) begin n_miss++; $display("FAIL uf_status got %h exp %h", d, 32'h8C000000); end
    bus_write(A_CTRL, 32'h00000004, 4'b0001);
    bus_read(A_STAT, d);
    n_vec++; if (d !== 32'h0C000000) begin n_miss++; $display("FAIL uf_clear got %h exp %h", d, 32'h0C000000); end
  endtask

  task automatic test_partial_write();
    logic [31:0] d;
    bus_write(A_DATA, 32'hCAFEF00D, 4'b1111);
    n_vec++; if (txValid !== 1'b1) begin n_miss++; $display("FAIL pw_txValid got %b exp 1", txValid); end
    n_vec++; if (txData !== 32'hCAFEF00D) begin n_miss++; $display("FAIL pw_txData got %h exp %h", txData, 32'hCAFEF00D); end
    bus_read(A_STAT, d);
    n_vec++; if (d !== 32'h08010000) begin n_miss++; $display("FAIL pw_status1 got %h exp %h", d, 32'h08010000); end
    bus_write(A_DATA, 32'h00001234, 4'b0011);
    bus_read(A_STAT, d);
    n_vec++; if (d !== 32'h08010000) begin n_miss++; $display("FAIL pw_partial got %h exp %h", d, 32'h08010000); end
    bus_write(A_MISS, 32'h99999999, 4'b1111);
    bus_read(A_STAT, d);
    n_vec++; if (d !== 32'h08010000) begin n_miss++; $display("FAIL pw_miss_write got %h exp %h", d, 32'h08010000); end
    bus_read(A_MISS, d);
    n_vec++; if (d !== 32'h0) begin n_miss++; $display("FAIL pw_miss_read got %h exp 0", d); end
    bus_write(A_CTRL, 32'h00000002, 4'b0001);
    bus_read(A_STAT, d);
    n_vec++; if (d !== 32'h0C000000) begin n_miss++; $display("FAIL pw_tx_flush got %h exp %h", d, 32'h0C000000); end
    n_vec++; if (txValid !== 1'b0) begin n_miss++; $display("FAIL pw_flush_txValid got %b exp 0", txValid); end
  endtask

  task automatic test_tx_overflow();
    logic [31:0] d;
    for (int i = 0; i < 17; i++) bus_write(A_DATA, 32'hA0000000 + 32'(i), 4'b1111);
    bus_read(A_STAT, d);
    n_vec++; if (d !== 32'h58100000) begin n_miss++; $display("FAIL of_status got %h exp %h", d, 32'h58100000); end
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      n_vec++;
      if (txData !== 32'hA0000000 + 32'(i) || txValid !== 1'b1) begin
        n_miss++; $display("FAIL of_drain%0d got %h/%b exp %h/1", i, txData, txValid, 32'hA0000000 + 32'(i));
      end
      txReady = 1'b1;
    end
    @(negedge clk);
    txReady = 1'b0;
    n_vec++; if (txValid !== 1'b0) begin n_miss++; $display("FAIL of_drained_txValid got %b exp 0", txValid); end
    bus_write(A_CTRL, 32'h00000008, 4'b0001);
    bus_read(A_STAT, d);
    n_vec++; if (d !== 32'h0C000000) begin n_miss++; $display("FAIL of_clear got %h exp %h", d, 32'h0C000000); end
  endtask

  task automatic test_rx_flush();
    logic [31:0] d;
    fabric_push(32'h0000AAAA);
    fabric_push(32'h0000BBBB);
    bus_read(A_CTRL, d);
    n_vec++; if (d !== 32'h0) begin n_miss++; $display("FAIL ctrl_read got %h exp 0", d); end
    bus_read(A_RSV, d);
    n_vec++; if (d !== 32'h0) begin n_miss++; $display("FAIL rsv_read got %h exp 0", d); end
    bus_read(A_STAT, d);
    n_vec++; if (d !== 32'h04000002) begin n_miss++; $display("FAIL fl_status2 got %h exp %h", d, 32'h04000002); end
    bus_write(A_CTRL, 32'h00000001, 4'b0001);
    bus_read(A_STAT, d);
    n_vec++; if (d !== 32'h0C000000) begin n_miss++; $display("FAIL fl_status0 got %h exp %h", d, 32'h0C000000); end
  endtask

  task automatic test_addr_change_abort();
    logic [31:0] d;
    fabric_push(32'h55555555);
    fabric_push(32'h66666666);
    @(negedge clk);
    cs = 1'b1; addr = A_DATA; {wr3, wr2, wr1, wr0} = 4'b0000;
    @(negedge clk);
    addr = A_STAT;
    n_vec++; if (dataOut !== 32'h55555555) begin n_miss++; $display("FAIL ac_first got %h exp %h", dataOut, 32'h55555555); end
    @(negedge clk);
    n_vec++; if (dataOut !== 32'h55555555) begin n_miss++; $display("FAIL ac_hold got %h exp %h", dataOut, 32'h55555555); end
    cs = 1'b0;
    @(negedge clk);
    n_vec++; if (dataOut !== 32'h0) begin n_miss++; $display("FAIL ac_release got %h exp 0", dataOut); end
    bus_read(A_STAT, d);
    n_vec++; if (d !== 32'h04000001) begin n_miss++; $display("FAIL ac_status got %h exp %h", d, 32'h04000001); end
    bus_read(A_DATA, d);
    n_vec++; if (d !== 32'h66666666) begin n_miss++; $display("FAIL ac_next got %h exp %h", d, 32'h66666666); end
  endtask

  task automatic test_full_and_reset();
    logic [31:0] d;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      rxValid = 1'b1; rxData = 32'hB0 + 32'(i);
    end
    @(negedge clk);
    rxData = 32'h0000DEAD;
    n_vec++; if (rxReady !== 1'b0) begin n_miss++; $display("FAIL full_rxReady got %b exp 0", rxReady); end
    bus_read(A_DATA, d);
    rxValid = 1'b0;
    n_vec++; if (d !== 32'hB0) begin n_miss++; $display("FAIL full_pop got %h exp %h", d, 32'hB0); end
    n_vec++; if (rxReady !== 1'b1) begin n_miss++; $display("FAIL full_after_pop_rxReady got %b exp 1", rxReady); end
    bus_read(A_STAT, d);
    n_vec++; if (d !== 32'h0400000F) begin n_miss++; $display("FAIL full_status15 got %h exp %h", d, 32'h0400000F); end
    bus_read(A_DATA, d);
    n_vec++; if (d !== 32'hB1) begin n_miss++; $display("FAIL full_order got %h exp %h", d, 32'hB1); end
    bus_write(A_DATA, 32'h00000077, 4'b1111);
    @(negedge clk);
    cs = 1'b1; addr = A_DATA;
    @(negedge clk);
    n_vec++; if (dataOut !== 32'hB2) begin n_miss++; $display("FAIL mid_read got %h exp %h", dataOut, 32'hB2); end
    resetN = 1'b0;
    #1;
    n_vec++; if (dataOut !== 32'h0) begin n_miss++; $display("FAIL mid_reset_dataOut got %h exp 0", dataOut); end
    n_vec++; if (txValid !== 1'b0 || txData !== 32'h0) begin n_miss++; $display("FAIL mid_reset_tx got %b/%h exp 0/0", txValid, txData); end
    n_vec++; if (rxReady !== 1'b0) begin n_miss++; $display("FAIL mid_reset_rxReady got %b exp 0", rxReady); end
    @(negedge clk);
    cs = 1'b0;
    @(negedge clk);
    resetN = 1'b1;
    @(negedge clk);
    bus_read(A_STAT, d);
    n_vec++; if (d !== 32'h0C000000) begin n_miss++; $display("FAIL after_reset_status got %h exp %h", d, 32'h0C000000); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_rx_order();
    test_underflow();
    test_partial_write();
    test_tx_overflow();
    test_rx_flush();
    test_addr_change_abort();
    test_full_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

`default_nettype wire
